// File: rtl/bp_fe_fetch_queue.sv
// Fetch queue between FE fetch and BE issue: buffers fetch packets and
// serialises them one instruction per handshake, with single-cycle flush.
module bp_fe_fetch_queue #(
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int fetch_width_p    = 2,
    parameter int els_p            = 8,
    parameter int metadata_width_p = 35,
    localparam int ptr_width_lp    = $clog2(els_p)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,

    input  logic                                    enq_v_i,
    output logic                                    enq_ready_o,
    input  logic [vaddr_width_p-1:0]                enq_pc_i,
    input  logic [fetch_width_p*instr_width_p-1:0]  enq_instr_i,
    input  logic [fetch_width_p-1:0]                enq_mask_i,
    input  logic [metadata_width_p-1:0]             enq_metadata_i,
    input  logic                                    enq_exc_v_i,
    input  logic [1:0]                              enq_exc_code_i,

    input  logic                                    flush_i,

    output logic                                    deq_v_o,
    input  logic                                    deq_yumi_i,
    output logic [vaddr_width_p-1:0]                deq_pc_o,
    output logic [instr_width_p-1:0]                deq_instr_o,
    output logic [metadata_width_p-1:0]             deq_metadata_o,
    output logic                                    deq_exc_v_o,
    output logic [1:0]                              deq_exc_code_o,

    output logic [ptr_width_lp:0]                   count_o
);

    localparam int lane_width_lp = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 1;
    localparam logic [ptr_width_lp:0] full_lp = (ptr_width_lp+1)'(els_p);

    logic [vaddr_width_p-1:0]                        pc_mem    [els_p];
    logic [fetch_width_p-1:0][instr_width_p-1:0]     instr_mem [els_p];
    logic [fetch_width_p-1:0]                        mask_mem  [els_p];
    logic [metadata_width_p-1:0]                     meta_mem  [els_p];
    logic                                            exc_mem   [els_p];
    logic [1:0]                                      code_mem  [els_p];

    logic [ptr_width_lp-1:0]   wptr, rptr;
    logic [ptr_width_lp:0]     count;
    logic [fetch_width_p-1:0]  consumed;

    logic [fetch_width_p-1:0]  remaining;
    logic [fetch_width_p-1:0]  lane_onehot;
    logic [lane_width_lp-1:0]  lane;
    logic                      lane_found;
    logic                      head_exc;
    logic                      last_lane;
    logic                      enq_fire;
    logic                      deq_fire;
    logic                      pop;

    assign enq_ready_o = (count != full_lp);
    assign deq_v_o     = (count != '0);
    assign count_o     = count;

    assign enq_fire = enq_v_i & enq_ready_o & ~flush_i & (enq_exc_v_i | (|enq_mask_i));
    assign deq_fire = deq_yumi_i & deq_v_o;

    // Head lane is the lowest valid lane not yet handed to the consumer.
    always_comb begin
        remaining   = mask_mem[rptr] & ~consumed;
        lane        = '0;
        lane_onehot = '0;
        lane_found  = 1'b0;
        for (int unsigned i = 0; i < fetch_width_p; i++) begin
            if (remaining[i] && !lane_found) begin
                lane_found     = 1'b1;
                lane           = lane_width_lp'(i);
                lane_onehot[i] = 1'b1;
            end
        end
    end

    assign head_exc  = exc_mem[rptr];
    assign last_lane = head_exc | ((remaining & ~lane_onehot) == '0);
    assign pop       = deq_fire & last_lane;

    assign deq_pc_o       = head_exc ? pc_mem[rptr]
                                     : pc_mem[rptr] + (vaddr_width_p'(lane) << 2);
    assign deq_instr_o    = head_exc ? '0 : instr_mem[rptr][lane];
    assign deq_metadata_o = meta_mem[rptr];
    assign deq_exc_v_o    = deq_v_o & head_exc;
    assign deq_exc_code_o = code_mem[rptr];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            consumed <= '0;
        end else if (flush_i) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            consumed <= '0;
        end else begin
            if (enq_fire) wptr <= wptr + ptr_width_lp'(1);
            if (pop)      rptr <= rptr + ptr_width_lp'(1);
            if (enq_fire && !pop)
                count <= count + (ptr_width_lp+1)'(1);
            else if (pop && !enq_fire)
                count <= count - (ptr_width_lp+1)'(1);
            if (deq_fire)
                consumed <= last_lane ? '0 : (consumed | lane_onehot);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            pc_mem[wptr]    <= enq_pc_i;
            instr_mem[wptr] <= enq_instr_i;
            mask_mem[wptr]  <= enq_mask_i;
            meta_mem[wptr]  <= enq_metadata_i;
            exc_mem[wptr]   <= enq_exc_v_i;
            code_mem[wptr]  <= enq_exc_code_i;
        end
    end

    yumi_requires_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        deq_yumi_i |-> deq_v_o)
        else $error("deq_yumi_i asserted while deq_v_o is low");

endmodule
